// File: rtl/wb_stage_regfile.sv
// Write-back stage: selects the write-back value and commits it to the register file.
// It also serves two bypassed ID read ports, drives the forwarding outputs and counts committed writes.
module wb_stage_regfile #(
  parameter int XLEN         = 32,
  parameter int NREGS        = 32,
  parameter int BLANK_CYCLES = 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [4:0]      IN_INSTRUCTION,
  input  logic [XLEN-1:0] IN_PC_4,
  input  logic [XLEN-1:0] IN_ALU_RESULT,
  input  logic [XLEN-1:0] IN_IMMEDIATE,
  input  logic [XLEN-1:0] IN_DMEM_OUT,
  input  logic [1:0]      IN_WB_SEL,
  input  logic            IN_REG_WRITE_EN,
  input  logic [4:0]      IN_RS1_ADDR,
  input  logic [4:0]      IN_RS2_ADDR,
  output logic [XLEN-1:0] OUT_RS1_DATA,
  output logic [XLEN-1:0] OUT_RS2_DATA,
  output logic [XLEN-1:0] OUT_WB_DATA,
  output logic [4:0]      OUT_WB_RD,
  output logic            OUT_WB_EN,
  output logic [31:0]     OUT_WB_COUNT
);

  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [31:0]     count_q, count_d;
  logic [BW-1:0]   blank_q, blank_d;
  logic [XLEN-1:0] wb_data;
  logic            wb_en;

  always_comb begin
    unique case (IN_WB_SEL)
      2'b00:   wb_data = IN_ALU_RESULT;
      2'b01:   wb_data = IN_DMEM_OUT;
      2'b10:   wb_data = IN_PC_4;
      default: wb_data = IN_IMMEDIATE;
    endcase
  end

  // Enable is gated by blanking and reset so flushed garbage never commits.
  always_comb begin
    wb_en = IN_REG_WRITE_EN & (blank_q == '0) & (IN_INSTRUCTION != '0) & ~RESET;
  end

  always_comb begin
    blank_d = (blank_q != '0) ? blank_q - 1'b1 : blank_q;
    count_d = count_q + {31'b0, wb_en};
    regs_d  = regs_q;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (wb_en && IN_INSTRUCTION == 5'(i)) regs_d[i] = wb_data;
    end
    regs_d[0] = '0;
  end

  // wb_en already excludes rd==0, so the bypass can never override x0.
  always_comb begin
    OUT_RS1_DATA = '0;
    OUT_RS2_DATA = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (IN_RS1_ADDR == 5'(i)) OUT_RS1_DATA = regs_q[i];
      if (IN_RS2_ADDR == 5'(i)) OUT_RS2_DATA = regs_q[i];
    end
    if (wb_en && IN_RS1_ADDR == IN_INSTRUCTION) OUT_RS1_DATA = wb_data;
    if (wb_en && IN_RS2_ADDR == IN_INSTRUCTION) OUT_RS2_DATA = wb_data;
  end

  always_comb begin
    OUT_WB_DATA  = wb_data;
    OUT_WB_RD    = IN_INSTRUCTION;
    OUT_WB_EN    = wb_en;
    OUT_WB_COUNT = count_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs_q  <= '{default: '0};
      count_q <= '0;
      blank_q <= BW'(BLANK_CYCLES);
    end else begin
      regs_q  <= regs_d;
      count_q <= count_d;
      blank_q <= blank_d;
    end
  end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile: reset/blanking, mux sweep, x0, bypass, counter wrap, mid-run reset.
module tb_wb_stage_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd;
  logic [31:0] pc_4, alu, imm, dmem;
  logic [1:0]  sel;
  logic        en;
  logic [4:0]  rs1, rs2;
  logic [31:0] rs1_data, rs2_data, wb_data, wb_count;
  logic [4:0]  wb_rd;
  logic        wb_en;

  int checks   = 0;
  int failures = 0;

  wb_stage_regfile #(.XLEN(32), .NREGS(32), .BLANK_CYCLES(1)) dut (
    .CLK(clk), .RESET(reset), .IN_INSTRUCTION(rd), .IN_PC_4(pc_4),
    .IN_ALU_RESULT(alu), .IN_IMMEDIATE(imm), .IN_DMEM_OUT(dmem),
    .IN_WB_SEL(sel), .IN_REG_WRITE_EN(en), .IN_RS1_ADDR(rs1), .IN_RS2_ADDR(rs2),
    .OUT_RS1_DATA(rs1_data), .OUT_RS2_DATA(rs2_data), .OUT_WB_DATA(wb_data),
    .OUT_WB_RD(wb_rd), .OUT_WB_EN(wb_en), .OUT_WB_COUNT(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic        en;
    logic [31:0] alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_en;
    logic [31:0] exp_data;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Starts right after reset release + first write: count=1, reg5=DEADBEEF.
    vecs[0]  = '{5'd1, 2'b00, 1'b1, 32'h11,       5'd1, 5'd5, 1'b1, 32'h11,       32'h11, 32'hDEADBEEF, 32'd2};
    vecs[1]  = '{5'd2, 2'b01, 1'b1, 32'h11,       5'd1, 5'd2, 1'b1, 32'h22,       32'h11, 32'h22,       32'd3};
    vecs[2]  = '{5'd3, 2'b10, 1'b1, 32'h11,       5'd2, 5'd3, 1'b1, 32'h33,       32'h22, 32'h33,       32'd4};
    vecs[3]  = '{5'd4, 2'b11, 1'b1, 32'h11,       5'd3, 5'd4, 1'b1, 32'h44,       32'h33, 32'h44,       32'd5};
    vecs[4]  = '{5'd4, 2'b11, 1'b0, 32'h11,       5'd1, 5'd4, 1'b0, 32'h44,       32'h11, 32'h44,       32'd5};
    vecs[5]  = '{5'd4, 2'b00, 1'b0, 32'h11,       5'd2, 5'd3, 1'b0, 32'h11,       32'h22, 32'h33,       32'd5};
    vecs[6]  = '{5'd0, 2'b00, 1'b1, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 32'hFFFFFFFF, 32'h0,  32'h0,        32'd5};
    vecs[7]  = '{5'd0, 2'b00, 1'b0, 32'h0,        5'd0, 5'd5, 1'b0, 32'h0,        32'h0,  32'hDEADBEEF, 32'd5};
    vecs[8]  = '{5'd7, 2'b00, 1'b1, 32'h100,      5'd7, 5'd7, 1'b1, 32'h100,      32'h100, 32'h100,     32'd6};
    vecs[9]  = '{5'd7, 2'b00, 1'b1, 32'h200,      5'd7, 5'd7, 1'b1, 32'h200,      32'h200, 32'h200,     32'd7};
    vecs[10] = '{5'd7, 2'b00, 1'b0, 32'h0,        5'd7, 5'd7, 1'b0, 32'h0,        32'h200, 32'h200,     32'd7};

    reset = 1'b1; rd = 5'd5; sel = 2'b00; en = 1'b1; alu = 32'hDEADBEEF;
    dmem = 32'h22; pc_4 = 32'h33; imm = 32'h44; rs1 = 5'd5; rs2 = 5'd0;

    // Reset held two edges, then blanking window.
    @(negedge clk); @(negedge clk); #1;
    check("reset_wb_en", {31'b0, wb_en}, 32'd0);
    check("reset_count", wb_count, 32'd0);
    check("reset_rs1", rs1_data, 32'd0);
    check("reset_wb_rd", {27'b0, wb_rd}, 32'd5);
    check("reset_wb_data", wb_data, 32'hDEADBEEF);
    reset = 1'b0; #1;
    check("blank_wb_en", {31'b0, wb_en}, 32'd0);
    @(negedge clk); #1;
    check("blank_count", wb_count, 32'd0);
    check("post_blank_wb_en", {31'b0, wb_en}, 32'd1);
    en = 1'b0; #1;
    check("blank_reg5_stored", rs1_data, 32'd0);
    en = 1'b1;
    @(negedge clk); en = 1'b0; #1;
    check("first_write_count", wb_count, 32'd1);
    check("first_write_reg5", rs1_data, 32'hDEADBEEF);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      rd = vecs[i].rd; sel = vecs[i].sel; en = vecs[i].en; alu = vecs[i].alu;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      #1;
      check($sformatf("v%0d_wb_en", i), {31'b0, wb_en}, {31'b0, vecs[i].exp_en});
      check($sformatf("v%0d_wb_data", i), wb_data, vecs[i].exp_data);
      check($sformatf("v%0d_rs1", i), rs1_data, vecs[i].exp_rs1);
      check($sformatf("v%0d_rs2", i), rs2_data, vecs[i].exp_rs2);
      @(posedge clk); #1;
      check($sformatf("v%0d_count", i), wb_count, vecs[i].exp_cnt);
    end

    // Counter wrap: preload all-ones, then one committed write.
    @(negedge clk); en = 1'b0;
    force dut.count_d = 32'hFFFFFFFF;
    @(posedge clk); #1;
    release dut.count_d;
    check("wrap_preload", wb_count, 32'hFFFFFFFF);
    @(negedge clk); rd = 5'd1; sel = 2'b00; alu = 32'h5; en = 1'b1;
    @(posedge clk); #1;
    check("wrap_count", wb_count, 32'd0);

    // Mid-operation reset concurrent with a write to the same register.
    @(negedge clk); rd = 5'd9; alu = 32'hABCD; en = 1'b1; rs1 = 5'd9;
    @(posedge clk); #1;
    check("mid_pre_count", wb_count, 32'd1);
    @(negedge clk); en = 1'b0; #1;
    check("mid_reg9_stored", rs1_data, 32'hABCD);
    reset = 1'b1; en = 1'b1; alu = 32'h1234; #1;
    check("mid_reset_wb_en", {31'b0, wb_en}, 32'd0);
    check("mid_reset_rs1", rs1_data, 32'hABCD);
    @(negedge clk); reset = 1'b0; #1;
    check("mid_blank_wb_en", {31'b0, wb_en}, 32'd0);
    check("mid_reg9_cleared", rs1_data, 32'd0);
    check("mid_count_cleared", wb_count, 32'd0);
    @(posedge clk); #1;
    check("mid_blank_count", wb_count, 32'd0);
    @(negedge clk); en = 1'b0; #1;
    check("mid_blank_reg9", rs1_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_stage_regfile.md
Name: wb_stage_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the registered MEM/WB fields, selects the write-back value and commits it to a 32x32 integer register file.
- Serves two read ports to the ID stage, with write-through bypass.
- Exports the current write-back value, destination and enable to the EX-stage forwarding unit.
- Keeps a count of committed register writes.

Parameters:
- XLEN, 32, data width of the register file and all data buses
- NREGS, 32, number of architectural registers; x0 is hardwired to zero
- BLANK_CYCLES, 1, cycles after RESET deassertion during which writes are suppressed while upstream pipeline registers flush

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  synchronous, active-high reset
- IN_INSTRUCTION  input  5  destination register rd (instruction bits [11:7])
- IN_PC_4  input  XLEN  PC+4 of the retiring instruction
- IN_ALU_RESULT  input  XLEN  ALU result
- IN_IMMEDIATE  input  XLEN  immediate (LUI path)
- IN_DMEM_OUT  input  XLEN  load data
- IN_WB_SEL  input  2  write-back source select
- IN_REG_WRITE_EN  input  1  register write request
- IN_RS1_ADDR  input  5  ID read port 1 address
- IN_RS2_ADDR  input  5  ID read port 2 address
- OUT_RS1_DATA  output  XLEN  read port 1 data
- OUT_RS2_DATA  output  XLEN  read port 2 data
- OUT_WB_DATA  output  XLEN  selected write-back value, to forwarding
- OUT_WB_RD  output  5  write-back destination, to forwarding
- OUT_WB_EN  output  1  qualified write enable, to forwarding
- OUT_WB_COUNT  output  32  committed-write counter

Behaviour:
- Reset is synchronous, active-high, single clock CLK. While RESET=1 at a rising edge:
  - all NREGS entries clear to 0
  - OUT_WB_COUNT clears to 0
  - blanking counter loads BLANK_CYCLES
- Blanking:
  - While the blanking counter is nonzero, qualified enable is 0 and the counter decrements each cycle.
  - X or garbage on MEM/WB inputs during this window must not corrupt state.
  - RESET reasserted mid-blanking reloads the counter.
- WB mux (combinational):
  - 2'b00 = IN_ALU_RESULT
  - 2'b01 = IN_DMEM_OUT
  - 2'b10 = IN_PC_4
  - 2'b11 = IN_IMMEDIATE
- Qualified enable: OUT_WB_EN = IN_REG_WRITE_EN & (blank count == 0) & (IN_INSTRUCTION != 0) & ~RESET.
- Forwarding outputs are combinational from the current inputs (zero latency):
  - OUT_WB_DATA = mux value
  - OUT_WB_RD = IN_INSTRUCTION
  - OUT_WB_EN as above
  - OUT_WB_DATA is driven even when OUT_WB_EN=0.
- Write: at a rising edge with OUT_WB_EN=1, reg[rd] <= mux value. Writes to x0 are never stored.
- Reads (combinational):
  - address 0 returns 0
  - if address equals OUT_WB_RD and OUT_WB_EN=1, the mux value is returned (same-cycle write-through bypass)
  - otherwise stored contents are returned
  - Both ports bypass independently; rs1==rs2==rd bypasses both.
- Counter:
  - OUT_WB_COUNT increments by 1 on every rising edge where OUT_WB_EN=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Not incremented for rd=0 or during blanking.
- Reset values:
  - OUT_WB_COUNT=0; all stored registers 0.
  - OUT_RS*_DATA reflect the cleared file (0) unless bypassed; bypass is inactive during reset since OUT_WB_EN=0.
  - OUT_WB_RD and OUT_WB_DATA follow the inputs.
- Priority: RESET over write; write and read of the same register in one cycle resolve via bypass (the new value is visible the same cycle).

Test Plan:
- Reset then blanking:
  - Hold RESET 2 cycles, release with IN_REG_WRITE_EN=1, rd=5, WB_SEL=00, ALU=0xDEADBEEF.
  - First post-reset edge: no write, reg5 stays 0, COUNT=0.
  - Next edge: reg5=0xDEADBEEF, COUNT=1.
- Mux select sweep, rd=1..4 with ALU=0x11, DMEM=0x22, PC_4=0x33, IMM=0x44 and WB_SEL=00/01/10/11 respectively:
  - Readback gives reg1=0x11, reg2=0x22, reg3=0x33, reg4=0x44.
  - COUNT advances by 4.
- x0 protection: write rd=0 value 0xFFFFFFFF, REG_WRITE_EN=1 -> OUT_WB_EN=0, RS1 at address 0 reads 0, COUNT unchanged.
- Bypass:
  - reg7 holds 0x100; drive a write rd=7 value 0x200 with RS1=RS2=7 in the same cycle.
  - Both read 0x200 before the edge; after the edge, with write disabled, both read 0x200.
- Counter wrap: preload COUNT via 2^32-1 writes (or force), one more write -> COUNT=0.
- Mid-operation reset:
  - With reg9=0xABCD, assert RESET one cycle concurrent with a write to rd=9 of 0x1234.
  - Result: reg9=0, COUNT=0, and the following cycle is blanked.
